// File: rtl/dec_pkg.sv
// Shared definitions for the loadable down-counter.
//   S_IDLE/S_COUNT/S_DONE : state encodings
//   state_t               : FSM state type built on those encodings
//   DEF_WIDTH             : default data width of the count path
package dec_pkg;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_COUNT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam int DEF_WIDTH = 7;

  typedef enum logic [1:0] {
    IDLE  = S_IDLE,
    COUNT = S_COUNT,
    DONE  = S_DONE
  } state_t;

endpackage

// File: rtl/dec_counter.sv
// Loadable down-counter with optional auto-reload.
// Loads a start value, counts down once per enabled edge, pulses done for
// one cycle on terminal count and, with wrap_en, reloads to give a periodic
// tick of reload+1 enabled cycles.
// Ports:
//   clk     : clock, rising edge
//   reset   : asynchronous active-low reset, clears all state
//   load    : load d into q and the reload register (priority over en)
//   d       : start/reload value
//   en      : count enable
//   wrap_en : reload at terminal count (sampled in DONE with en=1)
//   q       : current count (registered)
//   zero    : q == 0 (combinational decode of q)
//   done    : registered one-cycle terminal-count pulse
//   busy    : high while counting
module dec_counter
  import dec_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  input  logic             en,
  input  logic             wrap_en,
  output logic [WIDTH-1:0] q,
  output logic             zero,
  output logic             done,
  output logic             busy
);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] reload_r, reload_nxt;
  logic [WIDTH-1:0] q_nxt;
  logic             done_nxt;

  // Saturating decrement: the count floors at zero, never wraps to all-ones.
  function automatic logic [WIDTH-1:0] dec_sat(input logic [WIDTH-1:0] v);
    if (v == '0) return '0;
    return v - WIDTH'(1);
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      q        <= '0;
      reload_r <= '0;
      done     <= 1'b0;
    end else begin
      state    <= state_nxt;
      q        <= q_nxt;
      reload_r <= reload_nxt;
      done     <= done_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    q_nxt      = q;
    reload_nxt = reload_r;
    done_nxt   = 1'b0;

    if (load) begin
      q_nxt      = d;
      reload_nxt = d;
      if (d == '0) begin
        // A zero load is already terminal: report it straight away.
        state_nxt = DONE;
        done_nxt  = 1'b1;
      end else begin
        state_nxt = COUNT;
      end
    end else begin
      unique case (state)
        IDLE: begin
        end
        COUNT: begin
          if (en) begin
            q_nxt = dec_sat(q);
            if (q <= WIDTH'(1)) begin
              state_nxt = DONE;
              done_nxt  = 1'b1;
            end
          end
        end
        DONE: begin
          if (en && wrap_en) begin
            if (reload_r != '0) begin
              // Reload consumes an enabled cycle: period is reload+1.
              q_nxt     = reload_r;
              state_nxt = COUNT;
            end else begin
              done_nxt = 1'b1;
            end
          end
        end
        default: begin
          state_nxt = IDLE;
          q_nxt     = '0;
        end
      endcase
    end
  end

  assign zero = (q == '0);
  assign busy = (state == COUNT);

endmodule

// File: tb/tb_dec_counter.sv
module tb_dec_counter;

  logic       clk;
  logic       reset;
  logic       load;
  logic [6:0] d;
  logic       en;
  logic       wrap_en;
  logic [6:0] q;
  logic       zero;
  logic       done;
  logic       busy;

  int n_cmp;
  int n_err;

  dec_counter #(.WIDTH(7)) dut (
    .clk     (clk),
    .reset   (reset),
    .load    (load),
    .d       (d),
    .en      (en),
    .wrap_en (wrap_en),
    .q       (q),
    .zero    (zero),
    .done    (done),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [6:0] v);
    load = 1'b1;
    d    = v;
    step();
    load = 1'b0;
  endtask

  int exp_wrap_q[12]    = '{1, 0, 2, 1, 0, 2, 1, 0, 2, 1, 0, 2};
  int exp_wrap_done[12] = '{0, 1, 0, 0, 1, 0, 0, 1, 0, 0, 1, 0};
  int gate_en[4]        = '{1, 0, 1, 0};
  int gate_q[4]         = '{3, 3, 2, 2};
  int dn_cnt;

  initial begin
    n_cmp   = 0;
    n_err   = 0;
    reset   = 1'b0;
    load    = 1'b0;
    d       = '0;
    en      = 1'b0;
    wrap_en = 1'b0;

    // Reset state
    #20;
    chk("rst_q",    32'(q),    0);
    chk("rst_zero", 32'(zero), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    #2 reset = 1'b1;

    // Load 3 and count to zero
    step();
    do_load(7'd3);
    chk("ld3_q",    32'(q),    3);
    chk("ld3_busy", 32'(busy), 1);
    chk("ld3_done", 32'(done), 0);
    en = 1'b1;
    step();
    chk("c2_q",    32'(q),    2);
    chk("c2_busy", 32'(busy), 1);
    step();
    chk("c1_q",    32'(q),    1);
    chk("c1_busy", 32'(busy), 1);
    chk("c1_done", 32'(done), 0);
    step();
    chk("c0_q",    32'(q),    0);
    chk("c0_done", 32'(done), 1);
    chk("c0_busy", 32'(busy), 0);
    chk("c0_zero", 32'(zero), 1);
    step();
    chk("hold0_q",    32'(q),    0);
    chk("hold0_done", 32'(done), 0);

    // Auto-reload with period 3
    en      = 1'b0;
    wrap_en = 1'b1;
    do_load(7'd2);
    chk("wr_ld_q", 32'(q), 2);
    en = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      chk("wrap_q",    32'(q),    32'(exp_wrap_q[i]));
      chk("wrap_done", 32'(done), 32'(exp_wrap_done[i]));
      chk("wrap_nox",  32'($isunknown({q, zero, done, busy})), 0);
    end

    // Load priority over enable, then zero load
    en      = 1'b0;
    wrap_en = 1'b0;
    do_load(7'd5);
    chk("pri_ld5", 32'(q), 5);
    en = 1'b1;
    do_load(7'd9);
    chk("pri_q",    32'(q),    9);
    chk("pri_done", 32'(done), 0);
    do_load(7'd0);
    chk("z_q",    32'(q),    0);
    chk("z_done", 32'(done), 1);
    chk("z_busy", 32'(busy), 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("z_hold_q",    32'(q),    0);
      chk("z_hold_done", 32'(done), 0);
    end

    // Asynchronous reset mid-count
    en = 1'b0;
    do_load(7'd100);
    en = 1'b1;
    for (int i = 0; i < 10; i++) step();
    chk("ar_pre_q",    32'(q),    90);
    chk("ar_pre_busy", 32'(busy), 1);
    #2 reset = 1'b0;
    #1;
    chk("ar_q",    32'(q),    0);
    chk("ar_busy", 32'(busy), 0);
    chk("ar_done", 32'(done), 0);
    chk("ar_zero", 32'(zero), 1);
    #1 reset = 1'b1;
    step();
    chk("ar_idle_q",    32'(q),    0);
    chk("ar_idle_busy", 32'(busy), 0);

    // Maximum load counts fully to zero without wrapping
    en = 1'b0;
    do_load(7'd127);
    chk("max_ld_q", 32'(q), 127);
    en     = 1'b1;
    dn_cnt = 0;
    for (int i = 0; i < 126; i++) begin
      step();
      if (done) dn_cnt++;
    end
    chk("max_126_q", 32'(q), 1);
    step();
    if (done) dn_cnt++;
    chk("max_127_q",    32'(q),    0);
    chk("max_127_done", 32'(done), 1);
    chk("max_pulses",   32'(dn_cnt), 1);
    step();
    chk("max_nowrap_q",    32'(q),    0);
    chk("max_nowrap_done", 32'(done), 0);

    // Enable gating
    en = 1'b0;
    do_load(7'd4);
    chk("gate_ld_q", 32'(q), 4);
    for (int i = 0; i < 4; i++) begin
      en = gate_en[i][0];
      step();
      chk("gate_q", 32'(q), 32'(gate_q[i]));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/dec_counter.md
Name: dec_counter

Overview:
- Loadable down-counter with auto-reload. It is the decrementing counterpart of the existing incrementer register and shares its 7-bit data path.
- Loads a start value, counts down one step per enabled clock, and flags terminal count with a one-cycle pulse.
- Optionally reloads and repeats, giving a periodic tick.
- Used as the countdown/timeout element alongside the incrementer in the sequential-circuit set.

Parameters:
- WIDTH, 7, data width of d, q and the internal reload register.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset; clears all state immediately when low.
- load  input  1  load request; q and reload register take d at the next edge.
- d  input  WIDTH  start/reload value, sampled only when load=1.
- en  input  1  count enable; one decrement per edge while high.
- wrap_en  input  1  auto-reload enable at terminal count.
- q  output  WIDTH  current count, registered.
- zero  output  1  q==0, combinational decode of the q register.
- done  output  1  registered one-cycle pulse when q reaches 0.
- busy  output  1  high while in COUNT state.

Behaviour:
- Reset (reset=0, asynchronous): q=0, reload register=0, state=IDLE, done=0, busy=0, zero=1. Takes effect immediately, including mid-count. The first edge after reset rises behaves as IDLE.
- States: IDLE, COUNT, DONE. busy = (state==COUNT).
- Load has priority in every state:
  - load=1: q<=d, reload<=d, en ignored that cycle.
  - d!=0: next state COUNT, done<=0.
  - d==0: next state DONE, done<=1 for one cycle.
- IDLE, load=0: hold q and ignore en.
- COUNT, load=0:
  - en=0: hold.
  - en=1, q>1: q<=q-1.
  - en=1, q==1: q<=0, state<=DONE, done<=1 for one cycle.
- DONE, load=0:
  - en=0, or en=1 with wrap_en=0: hold q=0, no done pulse.
  - en=1, wrap_en=1, reload!=0: q<=reload, state<=COUNT, done=0. The reload cycle consumes one enabled cycle, so the period is reload+1 enabled cycles per done pulse.
  - en=1, wrap_en=1, reload==0: stay DONE, q=0, done<=1 every enabled cycle.
- The count never goes below 0. There is no modular wrap to all-ones; underflow is impossible by construction.
- done is 0 in every cycle not listed above.
- Arithmetic: an unsigned WIDTH-bit decrement, used only when q>=1. The maximum load is 2^WIDTH-1 (127 at the default) and counts fully to 0.
- Latency: load-to-q is 1 edge. Terminal count to done is the same edge as q becoming 0. zero follows q combinationally.
- wrap_en is sampled only in DONE with en=1.

Decomposition:
- Shared package dec_pkg holds:
  - state encoding localparams (IDLE=2'd0, COUNT=2'd1, DONE=2'd2)
  - default WIDTH
- One module only. The next-state/decrement logic is small enough that no sub-module is warranted.

Test Plan:
- Reset then load: reset low 20ns, release, load=1 d=7'd3 one cycle, then en=1 -> q sequence 3,2,1,0; done high exactly on the edge q becomes 0; busy 1 for three cycles then 0; zero=1 at end.
- Auto-reload: load d=7'd2, wrap_en=1, en held high for 12 cycles -> q pattern 2,1,0,2,1,0,...; done pulses every 3rd cycle; no X on outputs.
- Load priority and zero load: load=1 with en=1 while q=5 -> q=d and no decrement. Then load d=0 -> state DONE, done pulses once, q stays 0 with en=1 and wrap_en=0.
- Async reset mid-count: load d=7'd100, count 10 cycles (q=90), drop reset between edges -> q=0, busy=0, done=0 immediately without waiting for a clock edge.
- Boundary max: load 7'd127 with en high -> reaches 0 after exactly 127 enabled edges, single done pulse, no wrap to 127 when wrap_en=0.
- Enable gating: en toggling 1,0,1,0 from q=4 -> q decrements only on en=1 edges (4,3,3,2,2); holds otherwise.
